pulse_mode_driver: RTL and testbench

Synchronous front end that turns the three raw board buttons (btn_3, btn_2, btn_0) into clean, mutually exclusive, fixed-width input pulses x1, x2, x3 for the pulse-mode asynchronous counter on the EGO1 board. It satisfies the pulse-mode input rules the asynchronous circuit relies on:
- at most one input pulse at a time;
- bounded pulse width;
- guaranteed quiet gap between pulses.

It sits between the button pins and the counter's x1/x2/x3 inputs, and reports issue activity for LED display.

---
 rtl/pulse_mode_driver.sv | 161 ++++++++++++++++
 tb/tb_pulse_mode_driver.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_mode_driver.sv
// pulse_mode_driver: debounces three buttons and issues one-hot, fixed-width
// pulses separated by a guaranteed quiet gap for a pulse-mode async counter.
module pulse_mode_driver #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 4,
    parameter int GAP_CYCLES      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_3,
    input  logic       btn_2,
    input  logic       btn_0,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] pulse_cnt
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ?
                          PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] P_LAST  = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] G_LAST  = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    // bit 0 feeds x1, bit 1 feeds x2, bit 2 feeds x3
    logic [2:0]    btn;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    rise;
    logic [2:0]    pending;
    logic [2:0]    grant;
    logic [DW-1:0] db_cnt [3];

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;
    logic [2:0]    x_q;
    logic [2:0]    x_n;

    assign btn = {btn_0, btn_2, btn_3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign rise = stable & ~stable_d;

    // A rise landing on its own grant edge re-queues cleanly, no overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | rise;
            if (|(rise & pending & ~grant)) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            x_q       <= '0;
            pulse_cnt <= '0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            x_q   <= x_n;
            if (|grant) begin
                pulse_cnt <= pulse_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        x_n     = '0;
        grant   = '0;
        unique case (state)
            IDLE: begin
                tcnt_n = '0;
                if (pending[0]) begin
                    grant = 3'b001;
                end else if (pending[1]) begin
                    grant = 3'b010;
                end else if (pending[2]) begin
                    grant = 3'b100;
                end
                if (|pending) begin
                    state_n = PULSE;
                    x_n     = grant;
                end
            end
            PULSE: begin
                if (tcnt == P_LAST) begin
                    state_n = GAP;
                    tcnt_n  = '0;
                end else begin
                    x_n    = x_q;
                    tcnt_n = tcnt + TW'(1);
                end
            end
            GAP: begin
                if (tcnt == G_LAST) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tcnt_n  = '0;
            end
        endcase
    end

    assign x1   = x_q[0];
    assign x2   = x_q[1];
    assign x3   = x_q[2];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_mode_driver.sv
// tb_pulse_mode_driver: directed scenarios plus random button traffic,
// checked every cycle against a timeline-based reference model.
module tb_pulse_mode_driver;
    localparam int D = 8;
    localparam int P = 4;
    localparam int G = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_3 = 1'b0;
    logic       btn_2 = 1'b0;
    logic       btn_0 = 1'b0;
    logic       x1;
    logic       x2;
    logic       x3;
    logic       busy;
    logic       overrun;
    logic [7:0] pulse_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pulse_mode_driver #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES(P),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_3(btn_3),
        .btn_2(btn_2),
        .btn_0(btn_0),
        .x1(x1),
        .x2(x2),
        .x3(x3),
        .busy(busy),
        .overrun(overrun),
        .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    // model: raw->sync pipeline, run-length debounce, pending set,
    // and a timeline counter m_t measured from the last grant edge
    bit m_s1[3];
    bit m_s2[3];
    bit m_st[3];
    bit m_pst[3];
    bit m_pend[3];
    int m_run[3];
    bit m_ovr;
    int m_cnt;
    bit m_act;
    int m_t;
    int m_ch;

    int cyc = 0;
    int n_rise[3];
    int last_rise[3];
    int hi_cnt[3];
    int busy_cnt;
    int overlap;
    bit prev_x[3];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0;
            m_pst[i] = 0; m_pend[i] = 0; m_run[i] = 0;
        end
        m_ovr = 0; m_cnt = 0; m_act = 0; m_t = 0; m_ch = 0;
    endtask

    task automatic model_step();
        int g;
        bit raw[3];
        bit rise;
        raw[0] = btn_3; raw[1] = btn_2; raw[2] = btn_0;
        g = -1;
        if (!m_act || m_t >= P + G) begin
            for (int i = 2; i >= 0; i--) if (m_pend[i]) g = i;
        end
        for (int i = 0; i < 3; i++) begin
            rise = m_st[i] && !m_pst[i];
            if (rise && m_pend[i] && g != i) m_ovr = 1;
            m_pend[i] = (m_pend[i] && g != i) || rise;
            m_pst[i] = m_st[i];
            if (m_s2[i] == m_st[i]) m_run[i] = 0;
            else if (m_run[i] + 1 == D) begin
                m_st[i] = !m_st[i];
                m_run[i] = 0;
            end else m_run[i]++;
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        if (g >= 0) begin
            m_act = 1; m_t = 0; m_ch = g;
            m_cnt = (m_cnt + 1) % 256;
        end else if (m_act && m_t < P + G) m_t++;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) begin
            n_rise[i] = 0; last_rise[i] = -1; hi_cnt[i] = 0;
        end
        busy_cnt = 0; overlap = 0;
    endtask

    task automatic tick();
        bit xs[3];
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        xs[0] = x1; xs[1] = x2; xs[2] = x3;
        chk("x1", x1, int'(m_act && m_ch == 0 && m_t < P));
        chk("x2", x2, int'(m_act && m_ch == 1 && m_t < P));
        chk("x3", x3, int'(m_act && m_ch == 2 && m_t < P));
        chk("busy", busy, int'(m_act && m_t < P + G));
        chk("overrun", overrun, int'(m_ovr));
        chk("pulse_cnt", pulse_cnt, m_cnt);
        chk("onehot", int'({x1, x2, x3} inside {3'b000, 3'b001,
            3'b010, 3'b100}), 1);
        for (int i = 0; i < 3; i++) begin
            if (xs[i]) hi_cnt[i]++;
            if (xs[i] && !prev_x[i]) begin
                n_rise[i]++;
                last_rise[i] = cyc;
            end
            prev_x[i] = xs[i];
        end
        if (busy) busy_cnt++;
        if (x1 && x3) overlap++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int c0;
        int hold[3];
        model_reset();
        clear_stats();
        for (int i = 0; i < 3; i++) prev_x[i] = 0;

        // reset
        @(negedge clk);
        chk("rst_x", int'({x1, x2, x3}), 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", pulse_cnt, 0);
        ticks(2);
        rst = 1'b0;
        clear_stats();
        ticks(100);
        chk("idle_pulses", n_rise[0] + n_rise[1] + n_rise[2], 0);

        // single clean press on btn_2
        clear_stats();
        btn_2 = 1'b1;
        c0 = cyc;
        ticks(60);
        chk("single_rise_edge", last_rise[1] - c0 - 1, 11);
        chk("single_width", hi_cnt[1], P);
        chk("single_busy", busy_cnt, P + G);
        chk("single_cnt", pulse_cnt, 1);
        chk("single_others", hi_cnt[0] + hi_cnt[2], 0);
        chk("single_ovr", overrun, 0);
        btn_2 = 1'b0;
        ticks(30);

        // bounce on btn_0
        clear_stats();
        for (int k = 0; k < 10; k++) begin
            btn_0 = ~btn_0;
            ticks(3);
        end
        btn_0 = 1'b0;
        ticks(40);
        chk("bounce_pulses", n_rise[2], 0);
        chk("bounce_cnt", pulse_cnt, 1);

        // simultaneous btn_3 + btn_0
        clear_stats();
        btn_3 = 1'b1;
        btn_0 = 1'b1;
        ticks(70);
        chk("simul_x1_n", n_rise[0], 1);
        chk("simul_x3_n", n_rise[2], 1);
        chk("simul_x1_width", hi_cnt[0], P);
        chk("simul_spacing", last_rise[2] - last_rise[0], P + G + 1);
        chk("simul_overlap", overlap, 0);
        chk("simul_cnt", pulse_cnt, 3);
        btn_3 = 1'b0;
        btn_0 = 1'b0;
        ticks(30);

        // overrun: second btn_2 press while the first is still pending
        clear_stats();
        chk("pre_ovr", overrun, 0);
        btn_3 = 1'b1;
        btn_2 = 1'b1;
        ticks(10);
        btn_2 = 1'b0;
        ticks(10);
        btn_2 = 1'b1;
        ticks(70);
        chk("ovr_x1_n", n_rise[0], 1);
        chk("ovr_x2_n", n_rise[1], 1);
        chk("ovr_flag", overrun, 1);
        btn_3 = 1'b0;
        btn_2 = 1'b0;
        ticks(40);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_cnt", pulse_cnt, 5);

        // random traffic
        for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 25);
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 3; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    hold[i] = $urandom_range(1, 25);
                    if (i == 0) btn_3 = ~btn_3;
                    if (i == 1) btn_2 = ~btn_2;
                    if (i == 2) btn_0 = ~btn_0;
                end
            end
            tick();
        end
        btn_3 = 1'b0;
        btn_2 = 1'b0;
        btn_0 = 1'b0;
        ticks(120);

        // reset mid-pulse with btn_3 held
        btn_3 = 1'b1;
        for (int k = 0; k < 100 && !x1; k++) tick();
        chk("mid_x1_up", x1, 1);
        rst = 1'b1;
        #1;
        chk("mid_x1_async", x1, 0);
        chk("mid_busy_async", busy, 0);
        chk("mid_cnt_async", pulse_cnt, 0);
        model_reset();
        ticks(2);
        rst = 1'b0;
        clear_stats();
        c0 = cyc;
        ticks(40);
        chk("mid_rise_edge", last_rise[0] - c0 - 1, 11);
        chk("mid_x1_n", n_rise[0], 1);
        btn_3 = 1'b0;
        ticks(30);

        // 256 pulses wrap pulse_cnt
        rst = 1'b1;
        model_reset();
        ticks(2);
        rst = 1'b0;
        clear_stats();
        for (int k = 0; k < 256; k++) begin
            btn_3 = 1'b1;
            ticks(12);
            btn_3 = 1'b0;
            ticks(12);
        end
        ticks(60);
        chk("wrap_pulses", n_rise[0], 256);
        chk("wrap_cnt", pulse_cnt, 0);
        chk("wrap_ovr", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
